// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution write-back path.
package conv_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Control flags carried alongside every pipeline stage's address and data.
  typedef struct packed {
    logic valid;  // stage holds a live beat
    logic acc;    // beat belongs to a slice > 0: read-modify-write
    logic last;   // beat is the final one of the output frame
  } stage_ctl_t;

  // Number of output pixels per channel map.
  function automatic int unsigned map_size(input int unsigned h, input int unsigned w);
    return h * w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_write_addr_cnt.sv
// Nested col/row/slice/channel counters and the write-address pointer.
// The address is an incrementing pointer plus a channel-base register.
module conv_write_addr_cnt
  import conv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           OUT_HEIGHT = 31,
  parameter int unsigned           OUT_WIDTH  = 31,
  parameter int unsigned           IN_DEPTH   = 1,
  parameter int unsigned           OUT_CH     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  acc_o,
  output logic                  last_o,
  output logic                  idle_o
);

  localparam int unsigned CW = cnt_width(OUT_WIDTH);
  localparam int unsigned RW = cnt_width(OUT_HEIGHT);
  localparam int unsigned SW = cnt_width(IN_DEPTH);
  localparam int unsigned OW = cnt_width(OUT_CH);
  localparam logic [ADDR_WIDTH-1:0] MAP_STEP = ADDR_WIDTH'(map_size(OUT_HEIGHT, OUT_WIDTH));

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [SW-1:0]         slice_q, slice_d;
  logic [OW-1:0]         och_q, och_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] chb_q, chb_d;

  logic col_last, row_last, slice_last, och_last;
  logic map_end, ch_end, frame_end;

  assign col_last   = (col_q   == CW'(OUT_WIDTH - 1));
  assign row_last   = (row_q   == RW'(OUT_HEIGHT - 1));
  assign slice_last = (slice_q == SW'(IN_DEPTH - 1));
  assign och_last   = (och_q   == OW'(OUT_CH - 1));
  assign map_end    = col_last && row_last;
  assign ch_end     = map_end && slice_last;
  assign frame_end  = ch_end && och_last;

  // Next-state for the counters and the address pointer on each accepted beat.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    col_d   = col_q;
    row_d   = row_q;
    slice_d = slice_q;
    och_d   = och_q;
    ptr_d   = ptr_q;
    chb_d   = chb_q;
    if (!enable_i) begin
      col_d   = '0;
      row_d   = '0;
      slice_d = '0;
      och_d   = '0;
      ptr_d   = BASE_ADDR;
      chb_d   = BASE_ADDR;
    end else if (step_i) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d   = row_last   ? '0 : row_q   + RW'(1);
      if (map_end)  slice_d = slice_last ? '0 : slice_q + SW'(1);
      if (ch_end)   och_d   = och_last   ? '0 : och_q   + OW'(1);
      if (frame_end) begin
        ptr_d = BASE_ADDR;
        chb_d = BASE_ADDR;
      end else if (ch_end) begin
        chb_d = chb_q + MAP_STEP;
        ptr_d = chb_q + MAP_STEP;
      end else if (map_end) begin
        ptr_d = chb_q;  // next input slice revisits the same channel map
      end else begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      slice_q <= '0;
      och_q   <= '0;
      ptr_q   <= BASE_ADDR;
      chb_q   <= BASE_ADDR;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      col_q   <= col_d;
      row_q   <= row_d;
      slice_q <= slice_d;
      och_q   <= och_d;
      ptr_q   <= ptr_d;
      chb_q   <= chb_d;
    end
  end

  assign addr_o = ptr_q;
  assign acc_o  = (slice_q != '0);
  assign last_o = frame_end;
  assign idle_o = (col_q == '0) && (row_q == '0) && (slice_q == '0) && (och_q == '0)
               && (ptr_q == BASE_ADDR) && (chb_q == BASE_ADDR);

endmodule

// File: rtl/conv_result_writer.sv
// Write-back engine: accumulates convolution results across input depth
// slices into the output feature-map memory via a 3-stage read-modify-write pipe.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           OUT_HEIGHT = 31,
  parameter int unsigned           OUT_WIDTH  = 31,
  parameter int unsigned           IN_DEPTH   = 1,
  parameter int unsigned           OUT_CH     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    stage_ctl_t ctl;
    addr_t      addr;
    data_t      data;
  } stage_t;

  // s0: accepted beat, drives the read; s1: read data returning; s2: write.
  stage_t s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;

  logic  accept;
  addr_t cnt_addr;
  logic  cnt_acc, cnt_last, cnt_idle;

  assign in_ready = enable & rst_n;
  assign accept   = in_valid & in_ready;

  conv_write_addr_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_HEIGHT (OUT_HEIGHT),
    .OUT_WIDTH  (OUT_WIDTH),
    .IN_DEPTH   (IN_DEPTH),
    .OUT_CH     (OUT_CH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .step_i   (accept),
    .addr_o   (cnt_addr),
    .acc_o    (cnt_acc),
    .last_o   (cnt_last),
    .idle_o   (cnt_idle)
  );

  // Pipeline advance; dropping enable empties every stage so in-flight beats are never written.
  always_comb begin
    s0_d = '0;
    s1_d = '0;
    s2_d = '0;
    if (enable) begin
      s0_d.ctl.valid = accept;
      s0_d.ctl.acc   = accept & cnt_acc;
      s0_d.ctl.last  = accept & cnt_last;
      s0_d.addr      = cnt_addr;
      s0_d.data      = in_data;
      s1_d           = s0_q;
      s2_d           = s1_q;
      // Accumulate wraps modulo 2^DATA_WIDTH.
      if (s1_q.ctl.acc) s2_d.data = s1_q.data + rd_data;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload fields are reset too, so rd_addr/wr_addr/wr_data read 0 under reset.
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rd_en      = s0_q.ctl.valid & s0_q.ctl.acc;
  assign rd_addr    = s0_q.addr;
  assign wr_en      = s2_q.ctl.valid;
  assign wr_addr    = s2_q.addr;
  assign wr_data    = s2_q.data;
  assign frame_done = s2_q.ctl.valid & s2_q.ctl.last;
  assign busy       = enable & (s0_q.ctl.valid | s1_q.ctl.valid | s2_q.ctl.valid | ~cnt_idle);

endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer with a 1-cycle-latency RAM and
// a cycle-scheduled reference model derived from beat index arithmetic.
module tb_conv_result_writer;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int H = 2;
  localparam int W = 3;
  localparam int D = 2;
  localparam int C = 2;
  localparam logic [AW-1:0] BASE = 16'h0100;
  localparam int MAP = H * W;
  localparam int FRAME = MAP * D * C;

  logic          clk, rst_n, enable, in_valid, in_ready;
  logic [DW-1:0] in_data, rd_data, wr_data;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_en, wr_en, busy, frame_done;

  conv_result_writer #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .OUT_HEIGHT (H), .OUT_WIDTH (W),
    .IN_DEPTH (D), .OUT_CH (C), .BASE_ADDR (BASE)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable), .in_valid (in_valid),
    .in_ready (in_ready), .in_data (in_data), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .busy (busy), .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 1-cycle-latency synchronous RAM.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  // Reference model: beat k of a frame maps to (och, slice, row, col) by division.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] din; bit acc; bit last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_rec_t;

  beat_t         exp_wr [int];
  logic [AW-1:0] exp_rd [int];
  logic [DW-1:0] model_mem [0:65535];
  int            cyc = 0;
  int            beat_idx = 0;
  wr_rec_t       wr_log [$];
  logic [AW-1:0] rd_log [$];
  int            fd_count = 0;
  logic [AW-1:0] fd_addr = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      beat_idx = 0;
      exp_wr.delete();
      exp_rd.delete();
    end else if (!enable) begin
      beat_idx = 0;
      if (exp_wr.exists(cyc))     exp_wr.delete(cyc);
      if (exp_wr.exists(cyc + 1)) exp_wr.delete(cyc + 1);
      if (exp_rd.exists(cyc))     exp_rd.delete(cyc);
    end else if (in_valid) begin
      beat_t b;
      int col, row, slc, och;
      col = beat_idx % W;
      row = (beat_idx / W) % H;
      slc = (beat_idx / MAP) % D;
      och = beat_idx / (MAP * D);
      b.addr = BASE + AW'(och * MAP + row * W + col);
      b.din  = in_data;
      b.acc  = (slc != 0);
      b.last = (beat_idx == FRAME - 1);
      exp_wr[cyc + 2] = b;
      if (b.acc) exp_rd[cyc] = b.addr;
      beat_idx = (beat_idx + 1) % FRAME;
    end
  end

  // Monitor: compares every cycle's read/write activity with the schedule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_wr.exists(cyc)) begin
        beat_t b;
        logic [DW-1:0] ev;
        b  = exp_wr[cyc];
        ev = b.acc ? DW'(model_mem[b.addr] + b.din) : b.din;
        check("wr_en", wr_en, 1);
        check("wr_addr", wr_addr, b.addr);
        check("wr_data", wr_data, ev);
        check("frame_done", frame_done, b.last);
        model_mem[b.addr] = ev;
        exp_wr.delete(cyc);
      end else begin
        check("wr_en_idle", wr_en, 0);
        check("frame_done_idle", frame_done, 0);
      end
      if (exp_rd.exists(cyc)) begin
        check("rd_en", rd_en, 1);
        check("rd_addr", rd_addr, exp_rd[cyc]);
        exp_rd.delete(cyc);
      end else begin
        check("rd_en_idle", rd_en, 0);
      end
      if (wr_en) wr_log.push_back('{wr_addr, wr_data});
      if (rd_en) rd_log.push_back(rd_addr);
      if (frame_done) begin
        fd_count++;
        fd_addr = wr_addr;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input int gaps);
    in_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n0, r0;
    logic [DW-1:0] last100;
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int a = 0; a < 32; a++) begin
      ram[int'(BASE) + a]       = '0;
      model_mem[int'(BASE) + a] = '0;
    end

    // Reset with toggling stimulus.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable   = i[0];
      in_valid = ~i[0];
      in_data  = DW'($urandom);
      #1;
      check("rst_ctrl", {in_ready, rd_en, wr_en, busy, frame_done}, 0);
      check("rst_addr", {rd_addr, wr_addr}, 0);
      check("rst_wr_data", wr_data, 0);
    end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Slice 0 of channel 0: plain writes, no reads.
    for (int i = 1; i <= 6; i++) send(DW'(i), 0);
    drain(4);
    check("s0_wr_count", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("s0_addr", wr_log[i].addr, 32'h100 + i);
      check("s0_data", wr_log[i].data, i + 1);
    end
    check("s0_no_reads", rd_log.size(), 0);
    check("s0_busy", busy, 1);

    // Slice 1 of channel 0: read-modify-write.
    for (int i = 1; i <= 6; i++) send(DW'(10 * i), 0);
    drain(4);
    for (int i = 0; i < 6; i++) begin
      check("s1_rd_addr", rd_log[i], 32'h100 + i);
      check("s1_addr", wr_log[6 + i].addr, 32'h100 + i);
      check("s1_data", wr_log[6 + i].data, 11 * (i + 1));
    end

    // Channel 1 completes the frame.
    for (int i = 0; i < 12; i++) send(DW'($urandom), 0);
    drain(4);
    check("ch1_start", wr_log[12].addr, 32'h106);
    check("frame_writes", wr_log.size(), 24);
    check("frame_done_count", fd_count, 1);
    check("frame_done_addr", fd_addr, 32'h10B);
    check("frame_idle_busy", busy, 0);

    // Beat 25 wraps to base with no read.
    r0 = rd_log.size();
    send(16'h0007, 0);
    drain(4);
    check("wrap_addr", wr_log[wr_log.size() - 1].addr, 32'h100);
    check("wrap_data", wr_log[wr_log.size() - 1].data, 32'h7);
    check("wrap_no_read", rd_log.size(), r0);

    // Finish slice 0, then flush four slice-1 beats mid-flight.
    for (int i = 0; i < 5; i++) send(DW'($urandom), 0);
    drain(4);
    n0 = wr_log.size();
    for (int i = 0; i < 4; i++) send(DW'($urandom), 0);
    enable = 1'b0;
    #1;
    check("flush_in_ready", in_ready, 0);
    check("flush_busy", busy, 0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    check("flush_in_ready_back", in_ready, 1);
    drain(4);
    check("flush_writes", wr_log.size(), n0 + 2);

    // Restart at base: slice 0 preload 0xFFF0, then overflow with gaps.
    r0 = rd_log.size();
    send(16'hFFF0, 0);
    drain(4);
    check("restart_addr", wr_log[wr_log.size() - 1].addr, 32'h100);
    check("restart_no_read", rd_log.size(), r0);
    for (int i = 0; i < 5; i++) send(DW'($urandom), $urandom_range(0, 3));
    send(16'h0020, $urandom_range(0, 3));
    for (int i = 0; i < 17; i++) send(DW'($urandom), $urandom_range(0, 3));
    drain(6);
    last100 = 'x;
    for (int i = 0; i < wr_log.size(); i++)
      if (wr_log[i].addr == 16'h0100) last100 = wr_log[i].data;
    check("overflow_wrap", last100, 32'h0010);
    check("frame_done_count2", fd_count, 2);
    check("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Write-back engine at the output end of the convolution datapath. The window address generator walks anchors row-major over each input depth slice. This block receives one convolution result per anchor in that same order and accumulates the results across input depth slices into the output feature-map memory. It generates the write addresses and performs read-modify-write for every slice after the first, then signals the end of each output frame.

## Interface
- ADDR_WIDTH, 16: memory address width
- DATA_WIDTH, 32: result and accumulator width
- OUT_HEIGHT, 31: output map rows
- OUT_WIDTH, 31: output map columns; OUT_HEIGHT*OUT_WIDTH must be ≥ 3
- IN_DEPTH, 1: input slices accumulated per output channel
- OUT_CH, 1: output channels (kernels) written consecutively
- BASE_ADDR, 0: address of channel 0, row 0, column 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  work enable; low clears counters and flushes the pipeline
- in_valid  in  1  result beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready at a clk edge
- in_data  in  DATA_WIDTH  convolution result
- rd_en  out  1  memory read request; synchronous read, 1-cycle latency
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  DATA_WIDTH  read data, valid the cycle after rd_en
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- busy  out  1  work in progress
- frame_done  out  1  one-cycle pulse after the final write of the final channel

## Operation
- in_ready = enable (combinational). The memory never back-pressures.
- Counters col, row, slice, och all reset to 0. On each accepted beat:
  - col increments.
  - At OUT_WIDTH-1, col wraps and row increments.
  - At OUT_HEIGHT-1, row wraps and slice increments.
  - At IN_DEPTH-1, slice wraps and och increments.
  - At OUT_CH-1, och wraps to 0. This is the frame end.
- Address = BASE_ADDR + och*OUT_HEIGHT*OUT_WIDTH + row*OUT_WIDTH + col, truncated to ADDR_WIDTH.
  - Keep it as an incrementing pointer plus a channel-base register; no multipliers.
  - On a slice wrap the pointer reloads the channel base.
  - On a channel wrap the channel base advances by OUT_HEIGHT*OUT_WIDTH.
  - On a frame end both reload BASE_ADDR.
- Slice 0: write in_data directly; no read is issued.
- Slice > 0: read the address, then write in_data + rd_data. The sum wraps modulo 2^DATA_WIDTH (two's complement, no saturation).
- Three-stage pipeline: S0 accept, S1 read, S2 write. Each stage carries valid, address, data, accumulate flag and last flag.
- enable low: counters and pointers reset to 0/BASE_ADDR at the next edge and all stage valid bits clear. In-flight beats are dropped and never written.
- busy = enable && (any stage valid || any counter/pointer not at its reset value).
- frame_done asserts in the same cycle as wr_en of the beat flagged last.

## Timing
- Cycle n is the interval after clk edge n. For a beat accepted at edge 0:
  - rd_en/rd_addr valid in cycle 0 (registered), only for slice > 0.
  - rd_data arrives in cycle 1.
  - wr_en/wr_addr/wr_data valid in cycle 2.
- Fixed latency of 3 edges from accept to the write being committed. Throughput is 1 beat per cycle.
- RAW safety: the next read of the same address is ≥ OUT_HEIGHT*OUT_WIDTH ≥ 3 beats later, so the earlier write has committed. No forwarding is needed.
- Gaps in in_valid create bubbles only; addresses stay consecutive across gaps.
- Outputs under reset: in_ready 0 (follows enable after release), rd_en 0, rd_addr 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, frame_done 0.

## Structure
- Shared package conv_pkg:
  - addr_t/data_t widths.
  - Pipeline stage struct: valid, addr, data, acc, last.
  - Helper constant MAP_SIZE = OUT_HEIGHT*OUT_WIDTH.
- One sub-module: conv_write_addr_cnt, holding the four nested counters, the pointer, the channel base and the last/first-slice flags. The top level holds the pipeline and the adder.

## Test plan
All scenarios use OUT_HEIGHT=2, OUT_WIDTH=3, IN_DEPTH=2, OUT_CH=2, BASE_ADDR=0x100, DATA_WIDTH=16, with a 1-cycle-latency RAM model.
- Reset: hold rst_n low with stimulus toggling -> all outputs 0; after release with enable=1, in_ready=1 and busy=0.
- Slice 0: beats 1..6 back-to-back -> wr_addr 0x100..0x105, wr_data 1..6, each 2 cycles after rd-stage timing; rd_en never high.
- Slice 1: beats 10,20,…,60 -> rd_addr 0x100..0x105, then wr_data 11,22,33,44,55,66 at the same addresses; channel 1 starts at 0x106.
- Full frame plus wrap: 24 beats -> frame_done exactly once, with the write to 0x10B; beat 25 writes 0x100 with no read.
- enable low for 1 cycle after 4 beats of slice 1 -> in_ready low that cycle, no writes for in-flight beats, next beat writes 0x100 with rd_en=0.
- Overflow and gaps: memory holds 0xFFF0, slice-1 beat 0x0020 arrives with random in_valid gaps -> wr_data 0x0010, and addresses stay consecutive.
